// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage ahead of decode.
// Owns the program counter, drives a synchronous-read instruction memory with
// the combinational next-PC, and runs the IDLE/RUN/HALTED start/halt handshake.
// Ports:
//   clk, reset (async, active-high)   clock and reset
//   Start, Stall                      run control
//   PcSrc, Jump                       redirect controls from decode
//   BranchOffset, JumpTarget          redirect operands from the datapath
//   ImemData / ImemAddr               instruction memory read data / address
//   Pc, Instr, Op                     currently presented instruction
//   InstrValid, Done                  RUN / HALTED indicators
//   CycleCount, InstrCount            saturating run statistics
module fetch_unit #(
    parameter int          PC_WIDTH    = 10,
    parameter int          INSTR_WIDTH = 9,
    parameter int unsigned START_ADDR  = 0,
    parameter int          OFF_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Start,
    input  logic                   Stall,
    input  logic                   PcSrc,
    input  logic [1:0]             Jump,
    input  logic [OFF_WIDTH-1:0]   BranchOffset,
    input  logic [PC_WIDTH-1:0]    JumpTarget,
    input  logic [INSTR_WIDTH-1:0] ImemData,
    output logic [PC_WIDTH-1:0]    ImemAddr,
    output logic [PC_WIDTH-1:0]    Pc,
    output logic [INSTR_WIDTH-1:0] Instr,
    output logic [5:0]             Op,
    output logic                   InstrValid,
    output logic                   Done,
    output logic [15:0]            CycleCount,
    output logic [15:0]            InstrCount
);

    localparam logic [PC_WIDTH-1:0] START_PC = PC_WIDTH'(START_ADDR);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_t;

    state_t state, state_next;

    logic [PC_WIDTH-1:0] next_pc;
    logic [PC_WIDTH-1:0] offset_ext;
    logic                clear_counts;
    logic                count_cycle;
    logic                count_instr;

    // Signed size cast sign-extends the offset to the PC width.
    assign offset_ext = PC_WIDTH'($signed(BranchOffset));

    always_comb begin
        state_next   = state;
        next_pc      = Pc;
        clear_counts = 1'b0;
        count_cycle  = 1'b0;
        count_instr  = 1'b0;
        InstrValid   = 1'b0;
        Done         = 1'b0;

        unique case (state)
            IDLE, HALTED: begin
                Done = (state == HALTED);
                if (Start) begin
                    state_next   = RUN;
                    next_pc      = START_PC;
                    clear_counts = 1'b1;
                end
            end
            RUN: begin
                InstrValid  = 1'b1;
                count_cycle = 1'b1;
                if (!Stall) begin
                    count_instr = 1'b1;
                    if (Jump[1]) begin
                        state_next = HALTED;
                    end else if (Jump == 2'b01) begin
                        next_pc = JumpTarget;
                    end else if (PcSrc) begin
                        next_pc = Pc + offset_ext;
                    end else begin
                        next_pc = Pc + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ImemAddr = next_pc;
    assign Instr    = ImemData;
    assign Op       = ImemData[INSTR_WIDTH-1 -: 6];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Pc         <= START_PC;
            CycleCount <= '0;
            InstrCount <= '0;
        end else begin
            Pc <= next_pc;
            if (clear_counts) begin
                CycleCount <= '0;
                InstrCount <= '0;
            end else begin
                if (count_cycle && CycleCount != '1) begin
                    CycleCount <= CycleCount + 16'd1;
                end
                if (count_instr && InstrCount != '1) begin
                    InstrCount <= InstrCount + 16'd1;
                end
            end
        end
    end

endmodule
